mem_arbiter: RTL and testbench

Shares the single external memory port between the fetch stage's instruction requests (imem) and the decode stage's load/store requests (dmem). Each requester has one outstanding transaction at a time. The arbiter captures each request, issues it to memory, and waits for completion. It then routes `mem_ready`/`mem_rdata` back to the owning requester. It sits between the pipeline stages and the memory/bus interface, and uses the codebase's `mem_in_type`/`mem_out_type` structs on all three sides.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arbiter_pkg
// Description : Memory request/response structs shared by the pipeline
//               stages, the memory arbiter and the memory/bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Request from a requester (or from the arbiter towards memory)
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  // Response from memory (or from the arbiter towards a requester)
  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one external memory port between instruction fetch
//               (imem) and load/store (dmem). Each requester has at most one
//               transaction outstanding; contention is resolved by granting
//               the port that was not granted last time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_I = 2'd1,
    S_WAIT_D = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  mem_in_type r_pend_i;
  mem_in_type r_pend_d;
  mem_in_type r_iss;
  logic       r_last_d;   // 1: the last grant went to dmem
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_acc_i;
  logic       w_acc_d;

  // A pulse is taken only when the port has nothing pending and is not in
  // flight; a port whose response completes this cycle is no longer in flight.
  assign w_acc_i = imem_in.mem_valid & ~r_pend_i.mem_valid &
                   ~((r_state == S_WAIT_I) & ~mem_out.mem_ready);
  assign w_acc_d = dmem_in.mem_valid & ~r_pend_d.mem_valid &
                   ~((r_state == S_WAIT_D) & ~mem_out.mem_ready);

  // Next state, grant selection, memory request and response routing
  always_comb begin
    w_state_nxt        = r_state;
    w_grant_i          = 1'b0;
    w_grant_d          = 1'b0;
    mem_in             = r_iss;
    imem_out.mem_ready = 1'b0;
    imem_out.mem_rdata = mem_out.mem_rdata;
    dmem_out.mem_ready = 1'b0;
    dmem_out.mem_rdata = mem_out.mem_rdata;
    case (r_state)
      S_IDLE: begin
        if (r_pend_i.mem_valid && r_pend_d.mem_valid) begin
          w_grant_i = r_last_d;
          w_grant_d = ~r_last_d;
        end else begin
          w_grant_i = r_pend_i.mem_valid;
          w_grant_d = r_pend_d.mem_valid;
        end
        // The pending register carries valid=1, which becomes the issue pulse
        if (w_grant_i) begin
          w_state_nxt = S_WAIT_I;
          mem_in      = r_pend_i;
        end else if (w_grant_d) begin
          w_state_nxt = S_WAIT_D;
          mem_in      = r_pend_d;
        end
      end
      S_WAIT_I: begin
        if (mem_out.mem_ready) begin
          imem_out.mem_ready = 1'b1;
          w_state_nxt        = S_IDLE;
        end
      end
      S_WAIT_D: begin
        if (mem_out.mem_ready) begin
          dmem_out.mem_ready = 1'b1;
          w_state_nxt        = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending capture, issued-request copy and last-grant tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pend_i <= '0;
      r_pend_d <= '0;
      r_iss    <= '0;
      r_last_d <= 1'b0;
    end else begin
      // Accept and grant of the same port are mutually exclusive: accepting
      // needs an empty pending slot, granting needs a full one.
      if (w_acc_i) begin
        r_pend_i <= imem_in;
      end else if (w_grant_i) begin
        r_pend_i.mem_valid <= 1'b0;
      end
      if (w_acc_d) begin
        r_pend_d <= dmem_in;
      end else if (w_grant_d) begin
        r_pend_d.mem_valid <= 1'b0;
      end
      if (w_grant_i) begin
        r_iss           <= r_pend_i;
        r_iss.mem_valid <= 1'b0;
        r_last_d        <= 1'b0;
      end else if (w_grant_d) begin
        r_iss           <= r_pend_d;
        r_iss.mem_valid <= 1'b0;
        r_last_d        <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a small memory model
//               and a scoreboard of expected issues and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  mem_in_type  imem_in = '0;
  mem_in_type  dmem_in = '0;
  mem_in_type  mem_in;
  mem_out_type imem_out;
  mem_out_type dmem_out;
  mem_out_type mem_out = '0;

  int vectors     = 0;
  int miscompares = 0;

  mem_in_type  exp_issue[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  mem_in_type  sb_e;
  logic [31:0] sb_r;

  // Memory model controls (written by the tests, read by the model)
  int   mm_lat  = 2;
  logic mm_spur = 1'b0;
  int   mm_cnt  = 0;
  logic [31:0] mm_addr = '0;

  mem_arbiter dut (
    .rst      (rst),
    .clk      (clk),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic mem_in_type mk_req(input logic instr, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_in_type q;
    q.mem_valid = 1'b1;
    q.mem_instr = instr;
    q.mem_addr  = addr;
    q.mem_wdata = wdata;
    q.mem_wstrb = wstrb;
    return q;
  endfunction

  // Memory model: ready mm_lat cycles after the valid cycle (mm_lat >= 2)
  always @(posedge clk) begin : mm
    logic        s_rst;
    logic        s_val;
    logic        s_spur;
    logic [31:0] s_addr;
    int          s_lat;
    s_rst  = rst;
    s_val  = mem_in.mem_valid;
    s_addr = mem_in.mem_addr;
    s_spur = mm_spur;
    s_lat  = mm_lat;
    #1;
    mem_out = '0;
    if (!s_rst) begin
      mm_cnt = 0;
    end else begin
      if (mm_cnt != 0) begin
        mm_cnt = mm_cnt - 1;
        if (mm_cnt == 0) begin
          mem_out.mem_ready = 1'b1;
          mem_out.mem_rdata = mem_data(mm_addr);
        end
      end
      if (s_val === 1'b1) begin
        mm_cnt  = s_lat - 1;
        mm_addr = s_addr;
      end
      if (s_spur) begin
        mem_out.mem_ready = 1'b1;
        mem_out.mem_rdata = 32'h0000_0BAD;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    vectors++;
    if (mem_in !== '0) begin
      miscompares++;
      $display("FAIL reset_mem_in: got %h, required 0", mem_in);
    end
    vectors++;
    if (imem_out.mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_imem_ready: got %b, required 0", imem_out.mem_ready);
    end
    vectors++;
    if (dmem_out.mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dmem_ready: got %b, required 0", dmem_out.mem_ready);
    end
    cyc();
    rst = 1'b1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    imem_in = '0;
    dmem_in = '0;
    exp_issue.delete();
    exp_i.delete();
    exp_d.delete();
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_single_fetch();
    imem_in = mk_req(1'b1, 32'h100, 32'h0, 4'h0);
    exp_issue.push_back(imem_in);
    exp_i.push_back(32'h13);
    @(negedge clk);
    vectors++;
    if (mem_in.mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_no_early_issue: got valid %b, required 0", mem_in.mem_valid);
    end
    cyc();
    imem_in.mem_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_in.mem_valid !== 1'b1 || mem_in.mem_addr !== 32'h100 || mem_in.mem_wstrb !== 4'h0) begin
      miscompares++;
      $display("FAIL fetch_issue: got valid %b addr %h wstrb %h, required 1 00000100 0",
               mem_in.mem_valid, mem_in.mem_addr, mem_in.mem_wstrb);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if (mem_in.mem_valid !== 1'b0 || mem_in.mem_addr !== 32'h100 || imem_out.mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_wait: got valid %b addr %h ready %b, required 0 00000100 0",
               mem_in.mem_valid, mem_in.mem_addr, imem_out.mem_ready);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if (imem_out.mem_ready !== 1'b1 || imem_out.mem_rdata !== 32'h13 || dmem_out.mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_response: got i_ready %b rdata %h d_ready %b, required 1 00000013 0",
               imem_out.mem_ready, imem_out.mem_rdata, dmem_out.mem_ready);
    end
    cyc();
  endtask

  task automatic test_simultaneous();
    int md = -1;
    int mi = -1;
    bit got_i = 1'b0;
    do_reset();
    imem_in = mk_req(1'b1, 32'h200, 32'h0, 4'h0);
    dmem_in = mk_req(1'b0, 32'h1000, 32'h0, 4'h0);
    exp_issue.push_back(dmem_in);
    exp_issue.push_back(imem_in);
    exp_d.push_back(mem_data(32'h1000));
    exp_i.push_back(mem_data(32'h200));
    cyc();
    imem_in.mem_valid = 1'b0;
    dmem_in.mem_valid = 1'b0;
    for (int c = 0; c < 20 && !got_i; c++) begin
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if (mem_in.mem_valid !== 1'b1 || mem_in.mem_addr !== 32'h1000) begin
          miscompares++;
          $display("FAIL simul_first_grant: got valid %b addr %h, required 1 00001000",
                   mem_in.mem_valid, mem_in.mem_addr);
        end
      end
      if (dmem_out.mem_ready === 1'b1) md = c;
      if (mem_in.mem_valid === 1'b1 && mem_in.mem_addr === 32'h200) mi = c;
      if (imem_out.mem_ready === 1'b1) got_i = 1'b1;
      cyc();
    end
    vectors++;
    if (!got_i || md < 0 || mi != md + 1) begin
      miscompares++;
      $display("FAIL simul_second_grant: got d_ready cycle %0d i_issue cycle %0d done %b, required i_issue = d_ready+1 and done",
               md, mi, got_i);
    end
  endtask

  task automatic test_store_during_fetch();
    mem_in_type st;
    st = mk_req(1'b0, 32'h2004, 32'hDEAD_BEEF, 4'hF);
    imem_in = mk_req(1'b1, 32'h300, 32'h0, 4'h0);
    exp_issue.push_back(imem_in);
    exp_issue.push_back(st);
    exp_i.push_back(mem_data(32'h300));
    exp_d.push_back(mem_data(32'h2004));
    cyc();
    imem_in.mem_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_in.mem_valid !== 1'b1 || mem_in.mem_addr !== 32'h300) begin
      miscompares++;
      $display("FAIL store_fetch_issue: got valid %b addr %h, required 1 00000300",
               mem_in.mem_valid, mem_in.mem_addr);
    end
    cyc();
    dmem_in = st;
    @(negedge clk);
    vectors++;
    if (mem_in.mem_valid !== 1'b0 || mem_in.mem_addr !== 32'h300) begin
      miscompares++;
      $display("FAIL store_hold_addr: got valid %b addr %h, required 0 00000300",
               mem_in.mem_valid, mem_in.mem_addr);
    end
    cyc();
    dmem_in.mem_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_out.mem_ready !== 1'b1 || mem_in.mem_addr !== 32'h300 || mem_in.mem_valid !== 1'b0 ||
        dmem_out.mem_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL store_fetch_done: got i_ready %b addr %h valid %b d_ready %b, required 1 00000300 0 0",
               imem_out.mem_ready, mem_in.mem_addr, mem_in.mem_valid, dmem_out.mem_ready);
    end
    cyc();
    @(negedge clk);
    vectors++;
    if (mem_in !== st) begin
      miscompares++;
      $display("FAIL store_issue: got %h, required %h", mem_in, st);
    end
    cyc();
    cyc();
    @(negedge clk);
    vectors++;
    if (dmem_out.mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL store_done: got d_ready %b, required 1", dmem_out.mem_ready);
    end
    cyc();
  endtask

  task automatic test_contention();
    int ni = 0;
    int nd = 0;
    int ri = 0;
    int rd = 0;
    mem_in_type qi;
    mem_in_type qd;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_issue.push_back(mk_req(1'b0, 32'h4000 + 32'(k * 16), 32'h1111_0000 + 32'(k),
                                 (k % 2 == 1) ? 4'h3 : 4'h0));
      exp_issue.push_back(mk_req(1'b1, 32'h500 + 32'(k * 16), 32'h0, 4'h0));
    end
    qd = mk_req(1'b0, 32'h4000, 32'h1111_0000, 4'h0);
    qi = mk_req(1'b1, 32'h500, 32'h0, 4'h0);
    dmem_in = qd;
    imem_in = qi;
    exp_d.push_back(mem_data(qd.mem_addr));
    exp_i.push_back(mem_data(qi.mem_addr));
    ni = 1;
    nd = 1;
    for (int c = 0; c < 200 && !(ri == 3 && rd == 3); c++) begin
      @(negedge clk);
      if (imem_out.mem_ready === 1'b1) begin
        ri++;
        if (ni < 3) begin
          imem_in = mk_req(1'b1, 32'h500 + 32'(ni * 16), 32'h0, 4'h0);
          exp_i.push_back(mem_data(imem_in.mem_addr));
          ni++;
        end
      end
      if (dmem_out.mem_ready === 1'b1) begin
        rd++;
        if (nd < 3) begin
          dmem_in = mk_req(1'b0, 32'h4000 + 32'(nd * 16), 32'h1111_0000 + 32'(nd),
                           (nd % 2 == 1) ? 4'h3 : 4'h0);
          exp_d.push_back(mem_data(dmem_in.mem_addr));
          nd++;
        end
      end
      cyc();
      imem_in.mem_valid = 1'b0;
      dmem_in.mem_valid = 1'b0;
    end
    vectors++;
    if (ri != 3 || rd != 3 || exp_issue.size() != 0) begin
      miscompares++;
      $display("FAIL contention_count: got i_ready %0d d_ready %0d issues left %0d, required 3 3 0",
               ri, rd, exp_issue.size());
    end
  endtask

  task automatic test_reset_mid();
    bit got_i = 1'b0;
    do_reset();
    mm_lat  = 4;
    dmem_in = mk_req(1'b0, 32'h6000, 32'h0, 4'h0);
    exp_issue.push_back(dmem_in);
    cyc();
    dmem_in.mem_valid = 1'b0;
    cyc();
    imem_in = mk_req(1'b1, 32'h700, 32'h0, 4'h0);
    cyc();
    imem_in.mem_valid = 1'b0;
    rst = 1'b0;
    exp_issue.delete();
    exp_d.delete();
    cyc();
    @(negedge clk);
    vectors++;
    if (mem_in !== '0 || imem_out !== '0 || dmem_out !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got mem_in %h imem_out %h dmem_out %h, required all 0",
               mem_in, imem_out, dmem_out);
    end
    cyc();
    rst     = 1'b1;
    mm_lat  = 2;
    mm_spur = 1'b1;
    cyc();
    mm_spur = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_out.mem_ready !== 1'b0 || dmem_out.mem_ready !== 1'b0 || mem_in.mem_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_spurious: got i_ready %b d_ready %b valid %b, required 0 0 0",
               imem_out.mem_ready, dmem_out.mem_ready, mem_in.mem_valid);
    end
    cyc();
    imem_in = mk_req(1'b1, 32'h800, 32'h0, 4'h0);
    exp_issue.push_back(imem_in);
    exp_i.push_back(mem_data(32'h800));
    cyc();
    imem_in.mem_valid = 1'b0;
    for (int c = 0; c < 10 && !got_i; c++) begin
      @(negedge clk);
      if (imem_out.mem_ready === 1'b1) got_i = 1'b1;
      cyc();
    end
    vectors++;
    if (!got_i) begin
      miscompares++;
      $display("FAIL midreset_new_fetch: got no ready within 10 cycles, required ready");
    end
  endtask

  initial begin
    // Scoreboard: every issue and every response must match the next expectation
    fork
      forever begin
        @(negedge clk);
        if (mem_in.mem_valid === 1'b1) begin
          vectors++;
          if (exp_issue.size() == 0) begin
            miscompares++;
            $display("FAIL sb_issue: got unexpected issue addr %h, required none", mem_in.mem_addr);
          end else begin
            sb_e = exp_issue.pop_front();
            if (mem_in !== sb_e) begin
              miscompares++;
              $display("FAIL sb_issue: got %h, required %h", mem_in, sb_e);
            end
          end
        end
        if (imem_out.mem_ready === 1'b1) begin
          vectors++;
          if (exp_i.size() == 0) begin
            miscompares++;
            $display("FAIL sb_imem: got unexpected ready rdata %h, required none", imem_out.mem_rdata);
          end else begin
            sb_r = exp_i.pop_front();
            if (imem_out.mem_rdata !== sb_r) begin
              miscompares++;
              $display("FAIL sb_imem: got rdata %h, required %h", imem_out.mem_rdata, sb_r);
            end
          end
        end
        if (dmem_out.mem_ready === 1'b1) begin
          vectors++;
          if (exp_d.size() == 0) begin
            miscompares++;
            $display("FAIL sb_dmem: got unexpected ready rdata %h, required none", dmem_out.mem_rdata);
          end else begin
            sb_r = exp_d.pop_front();
            if (dmem_out.mem_rdata !== sb_r) begin
              miscompares++;
              $display("FAIL sb_dmem: got rdata %h, required %h", dmem_out.mem_rdata, sb_r);
            end
          end
        end
      end
    join_none

    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store_during_fetch();
    test_contention();
    test_reset_mid();
    cyc();
    cyc();
    vectors++;
    if (exp_issue.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d/%0d/%0d outstanding, required 0/0/0",
               exp_issue.size(), exp_i.size(), exp_d.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
